// File: rtl/pool_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pool_job_arbiter
//  Purpose  : Round-robin owner of one shared pool_layer engine. Grants one
//             requesting core, pulses the engine start, waits for done under
//             a watchdog, returns ack/err to the owner and resets the engine.
//  Revision : 1.0  initial release
// ============================================================================
module pool_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic               pool_start_o,
  output logic               pool_rst_o,
  input  logic               pool_done_i,
  output logic               busy_o
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [TMR_W-1:0]   timer_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] err_q;
  logic               pool_start_q;
  logic               pool_rst_q;

  logic               pick_found_d;
  logic [IDX_W-1:0]   pick_idx_d;
  logic [NUM_REQ-1:0] pick_onehot_d;
  logic [IDX_W-1:0]   ptr_d;

  // Round-robin pick: first set request bit scanning ptr, ptr+1, ... (wrapping)
  always_comb begin
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int               pos;
      logic [IDX_W-1:0] pos_idx;
      pos = int'(ptr_q) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      pos_idx = IDX_W'(pos);
      if (!pick_found_d && req_i[pos_idx]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = pos_idx;
      end
    end
    pick_onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_d;
  end

  // Pointer moves just past the current owner, wrapping mod NUM_REQ
  always_comb begin
    ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
  end

  // Job controller: arbitration, start pulse, watchdog and release, all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      timer_q      <= '0;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      pool_start_q <= 1'b0;
      pool_rst_q   <= 1'b0;
    end else begin
      // pulse outputs last exactly one cycle unless re-asserted below
      ack_q        <= '0;
      err_q        <= '0;
      pool_start_q <= 1'b0;
      pool_rst_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found_d) begin
            grant_q      <= pick_onehot_d;
            grant_idx_q  <= pick_idx_d;
            pool_start_q <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          timer_q <= timer_q + TMR_W'(1);
          // done takes priority over the watchdog in the same cycle
          if (pool_done_i) begin
            ack_q      <= grant_q;
            pool_rst_q <= 1'b1;
            state_q    <= S_RELEASE;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            err_q      <= grant_q;
            pool_rst_q <= 1'b1;
            state_q    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          ptr_q       <= ptr_d;
          grant_q     <= '0;
          grant_idx_q <= '0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign grant_idx_o  = grant_idx_q;
  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign pool_start_o = pool_start_q;
  assign pool_rst_o   = pool_rst_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pool_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool_job_arbiter
//  Purpose  : Scoreboard bench for pool_job_arbiter. Two instances: index 0
//             with TIMEOUT=16, index 1 with TIMEOUT=256 for the long job.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pool_job_arbiter;

  localparam int K_START = 0;
  localparam int K_ACK   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int         kind;
    logic [3:0] vec;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req       [2];
  logic       pool_done [2];
  logic [3:0] grant     [2];
  logic [1:0] gidx      [2];
  logic [3:0] ack       [2];
  logic [3:0] err       [2];
  logic       pstart    [2];
  logic       prst      [2];
  logic       busy      [2];

  exp_t exp_q [2][$];
  int   dly_q [2][$];
  int   eng_cnt [2];
  int   last_evt [2];
  logic chk_next [2];

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  logic rst_seen = 1'b0;
  logic sim_done = 1'b0;

  always #5 clk = ~clk;

  pool_job_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(16)) u_dut_s (
    .clk(clk), .rst(rst), .req_i(req[0]), .grant_o(grant[0]),
    .grant_idx_o(gidx[0]), .ack_o(ack[0]), .err_o(err[0]),
    .pool_start_o(pstart[0]), .pool_rst_o(prst[0]),
    .pool_done_i(pool_done[0]), .busy_o(busy[0])
  );

  pool_job_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(256)) u_dut_l (
    .clk(clk), .rst(rst), .req_i(req[1]), .grant_o(grant[1]),
    .grant_idx_o(gidx[1]), .ack_o(ack[1]), .err_o(err[1]),
    .pool_start_o(pstart[1]), .pool_rst_o(prst[1]),
    .pool_done_i(pool_done[1]), .busy_o(busy[1])
  );

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  // cycle count and the reset level seen at each active edge
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Monitor: pops expectations whenever a DUT presents start/ack/err
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    logic [15:0] expv;
    for (int d = 0; d < 2; d++) begin
      act = {pstart[d], prst[d], ack[d], err[d], grant[d], gidx[d]};
      if (rst_seen) begin
        checks++;
        if (act != 16'h0 || busy[d]) begin
          errors++;
          $display("FAIL reset_zero dut=%0d actual=%h busy=%0b required=0000 busy=0", d, act, busy[d]);
        end
      end
      checks++;
      if ((busy[d] != (grant[d] != 4'd0)) || (pstart[d] && prst[d])) begin
        errors++;
        $display("FAIL invariant dut=%0d busy=%0b grant=%b start=%0b prst=%0b required busy==|grant and !(start&prst)",
                 d, busy[d], grant[d], pstart[d], prst[d]);
      end
      if (chk_next[d]) begin
        chk_next[d] = 1'b0;
        checks++;
        if (act != 16'h0 || busy[d]) begin
          errors++;
          $display("FAIL post_release dut=%0d actual=%h busy=%0b required=0000 busy=0", d, act, busy[d]);
        end
      end
      if (pstart[d] || ack[d] != 4'd0 || err[d] != 4'd0) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event dut=%0d actual=%h required=none", d, act);
        end else begin
          e = exp_q[d].pop_front();
          case (e.kind)
            K_START: expv = {1'b1, 1'b0, 4'd0,  4'd0,  e.vec, enc(e.vec)};
            K_ACK:   expv = {1'b0, 1'b1, e.vec, 4'd0,  e.vec, enc(e.vec)};
            default: expv = {1'b0, 1'b1, 4'd0,  e.vec, e.vec, enc(e.vec)};
          endcase
          checks++;
          if (act != expv) begin
            errors++;
            $display("FAIL event_k%0d dut=%0d actual=%h required=%h", e.kind, d, act, expv);
          end
          if (e.gap >= 0) begin
            checks++;
            if (cyc - last_evt[d] != e.gap) begin
              errors++;
              $display("FAIL gap_k%0d dut=%0d actual=%0d required=%0d", e.kind, d, cyc - last_evt[d], e.gap);
            end
          end
          last_evt[d] = cyc;
          if (e.kind != K_START) chk_next[d] = 1'b1;
        end
      end
    end
    if (sim_done) begin
      checks++;
      if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
        errors++;
        $display("FAIL leftover_expect actual=%0d/%0d required=0/0", exp_q[0].size(), exp_q[1].size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic push(input int d, input int k, input logic [3:0] v, input int g);
    exp_t e;
    e.kind = k;
    e.vec  = v;
    e.gap  = g;
    exp_q[d].push_back(e);
  endtask

  // One cycle of the engine and requester models for both instances
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pool_done[d] = 1'b0;
        eng_cnt[d]   = -1;
      end else begin
        if (prst[d]) pool_done[d] = 1'b0;
        if (pstart[d]) begin
          eng_cnt[d] = (dly_q[d].size() != 0) ? dly_q[d].pop_front() : -1;
        end else if (busy[d] && eng_cnt[d] > 0) begin
          eng_cnt[d]--;
          if (eng_cnt[d] == 0) pool_done[d] = 1'b1;
        end
        req[d] = req[d] & ~(ack[d] | err[d]);
      end
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (!(exp_q[d].size() == 0 && busy[d] == 1'b0)) begin
      tick();
      n++;
      if (n > 2000) begin
        $display("FAIL drain_timeout dut=%0d pending=%0d required=0", d, exp_q[d].size());
        $fatal(1);
      end
    end
  endtask

  task automatic wait_popped(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0) begin
      tick();
      n++;
      if (n > 200) begin
        $display("FAIL start_timeout dut=%0d pending=%0d required=0", d, exp_q[d].size());
        $fatal(1);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d]       = 4'd0;
      pool_done[d] = 1'b0;
      eng_cnt[d]   = -1;
      last_evt[d]  = 0;
      chk_next[d]  = 1'b0;
    end
    // long job on the 256-cycle instance; all four cores held from reset on the other
    req[1] = 4'b0001;
    req[0] = 4'b1111;
    repeat (3) tick();
    dly_q[1].push_back(40);
    push(1, K_START, 4'b0001, -1);
    push(1, K_ACK,   4'b0001, 41);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] v;
      v = 4'b0001 << k;
      dly_q[0].push_back(5);
      push(0, K_START, v, (k == 0) ? -1 : 2);
      push(0, K_ACK,   v, 6);
    end
    rst = 1'b0;
    wait_drain(0);
    wait_drain(1);

    // serve core 2 alone, then 0101 wraps to core 0 before core 2
    dly_q[0].push_back(3);
    push(0, K_START, 4'b0100, -1);
    push(0, K_ACK,   4'b0100, 4);
    req[0] = 4'b0100;
    wait_drain(0);
    dly_q[0].push_back(3);
    dly_q[0].push_back(3);
    push(0, K_START, 4'b0001, -1);
    push(0, K_ACK,   4'b0001, 4);
    push(0, K_START, 4'b0100, 2);
    push(0, K_ACK,   4'b0100, 4);
    req[0] = 4'b0101;
    wait_drain(0);

    // watchdog abort of core 1, then core 2 served normally
    dly_q[0].push_back(-1);
    dly_q[0].push_back(3);
    push(0, K_START, 4'b0010, -1);
    push(0, K_ERR,   4'b0010, 17);
    push(0, K_START, 4'b0100, 2);
    push(0, K_ACK,   4'b0100, 4);
    req[0] = 4'b0110;
    wait_drain(0);

    // done arrives on the last BUSY cycle: ack wins
    dly_q[0].push_back(16);
    push(0, K_START, 4'b1000, -1);
    push(0, K_ACK,   4'b1000, 17);
    req[0] = 4'b1000;
    wait_drain(0);

    // reset during BUSY with core 2 holding its request
    dly_q[0].push_back(-1);
    push(0, K_START, 4'b0100, -1);
    req[0] = 4'b0100;
    wait_popped(0);
    repeat (5) tick();
    rst = 1'b1;
    dly_q[0].push_back(2);
    push(0, K_START, 4'b0100, -1);
    push(0, K_ACK,   4'b0100, 3);
    tick();
    rst = 1'b0;
    wait_drain(0);

    // pointer returns to 0 on reset: park ptr at 2, abort core 3, 0110 -> core 1 first
    dly_q[0].push_back(2);
    push(0, K_START, 4'b0010, -1);
    push(0, K_ACK,   4'b0010, 3);
    req[0] = 4'b0010;
    wait_drain(0);
    dly_q[0].push_back(-1);
    push(0, K_START, 4'b1000, -1);
    req[0] = 4'b1000;
    wait_popped(0);
    repeat (4) tick();
    rst    = 1'b1;
    req[0] = 4'b0110;
    dly_q[0].push_back(2);
    dly_q[0].push_back(2);
    push(0, K_START, 4'b0010, -1);
    push(0, K_ACK,   4'b0010, 3);
    push(0, K_START, 4'b0100, 2);
    push(0, K_ACK,   4'b0100, 3);
    tick();
    rst = 1'b0;
    wait_drain(0);

    repeat (2) tick();
    sim_done = 1'b1;
    repeat (10) @(negedge clk);
    $display("FAIL finish_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
